// File: rtl/alu_iter_if.sv
// alu_iter_if: handshake bundle for the iterative integer execution unit.
//   Request side : in_valid, in_ready, a, b, funct3_, funct7_, instr_type
//   Response side: out_valid, out_ready, c, illegal
// The master modport belongs to the producer/consumer (the core), and the
// slave modport belongs to the execution unit.
interface alu_iter_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [2:0]      funct3_;
  logic [6:0]      funct7_;
  logic [3:0]      instr_type;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] c;
  logic            illegal;

  modport master (
    output in_valid, a, b, funct3_, funct7_, instr_type, out_ready,
    input  in_ready, out_valid, c, illegal
  );

  modport slave (
    input  in_valid, a, b, funct3_, funct7_, instr_type, out_ready,
    output in_ready, out_valid, c, illegal
  );
endinterface

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle RV32I ALU plus RV32M MUL (low half).
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : alu_iter_if.slave request/response handshake (XLEN must match)
//   busy   : high whenever the unit is not IDLE
// Single-cycle ops and illegal encodings reach DONE on the accept edge.
// Shifts move at most SHIFT_STEP bits per cycle; MUL is shift-add, one
// multiplier bit per cycle for XLEN cycles. c/illegal are registered and held
// in DONE until the consumer takes them.
module alu_iter #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic       clk,
  input  logic       reset,
  alu_iter_if.slave  bus,
  output logic       busy
);

  localparam int SW = $clog2(XLEN);
  localparam logic [SW:0] STEP_MAX = (SW+1)'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] c_q;
  logic            illegal_q;

  // Shift datapath
  logic [XLEN-1:0] sh_val;
  logic [SW-1:0]   sh_rem;
  logic            sh_left;
  logic            sh_arith;

  // Multiply datapath
  logic [XLEN-1:0] mul_acc;
  logic [XLEN-1:0] mul_mcand;
  logic [XLEN-1:0] mul_mplier;
  logic [SW-1:0]   mul_cnt;

  // ------------------------------------------------------------------
  // Decode of the presented operation (only consumed in IDLE on accept).
  // ------------------------------------------------------------------
  logic            dec_illegal;
  logic            dec_alt;     // SUB for funct3 000, SRA for funct3 101
  logic            dec_mul;
  logic            dec_shift;
  logic [SW-1:0]   dec_shamt;
  logic [XLEN-1:0] alu_res;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    dec_illegal = 1'b0;
    dec_alt     = 1'b0;
    dec_mul     = 1'b0;
    case (bus.instr_type)
      4'd0: begin
        case (bus.funct7_)
          7'b0000000: ;
          7'b0100000: begin
            if (bus.funct3_ == 3'b000 || bus.funct3_ == 3'b101) dec_alt = 1'b1;
            else                                                dec_illegal = 1'b1;
          end
          7'b0000001: begin
            if (bus.funct3_ == 3'b000) dec_mul = 1'b1;
            else                       dec_illegal = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      4'd1: begin
        // I-type: funct7 carries immediate bits except for the shift forms.
        if (bus.funct3_ == 3'b001) begin
          if (bus.funct7_ != 7'b0000000) dec_illegal = 1'b1;
        end else if (bus.funct3_ == 3'b101) begin
          if (bus.funct7_ == 7'b0100000)      dec_alt = 1'b1;
          else if (bus.funct7_ != 7'b0000000) dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase

    dec_shift = !dec_illegal && (bus.funct3_ == 3'b001 || bus.funct3_ == 3'b101);
    dec_shamt = bus.b[SW-1:0];

    alu_res = '0;
    case (bus.funct3_)
      3'b000:  alu_res = dec_alt ? bus.a - bus.b : bus.a + bus.b;
      3'b010:  alu_res = XLEN'($signed(bus.a) < $signed(bus.b));
      3'b011:  alu_res = XLEN'(bus.a < bus.b);
      3'b100:  alu_res = bus.a ^ bus.b;
      3'b110:  alu_res = bus.a | bus.b;
      3'b111:  alu_res = bus.a & bus.b;
      default: alu_res = '0;
    endcase
  end

  // ------------------------------------------------------------------
  // Iteration step logic.
  // ------------------------------------------------------------------
  logic [SW:0]     sh_step;
  logic [XLEN-1:0] sh_next;
  logic [SW-1:0]   sh_rem_next;
  logic [XLEN-1:0] mul_sum;

  always_comb begin
    sh_step = ({1'b0, sh_rem} < STEP_MAX) ? {1'b0, sh_rem} : STEP_MAX;
    if (sh_left)       sh_next = sh_val << sh_step;
    else if (sh_arith) sh_next = $unsigned($signed(sh_val) >>> sh_step);
    else               sh_next = sh_val >> sh_step;
    // sh_step never exceeds sh_rem, so the low bits carry the whole step.
    sh_rem_next = sh_rem - sh_step[SW-1:0];
    mul_sum     = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  end

  // ------------------------------------------------------------------
  // Control FSM and registered results.
  // ------------------------------------------------------------------
  // NOTE: only the FSM state and the visible outputs are reset; the shift and
  // multiply datapath registers are always loaded on accept before being read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      c_q       <= '0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (dec_illegal) begin
              c_q       <= '0;
              illegal_q <= 1'b1;
              state     <= DONE;
            end else if (dec_mul) begin
              mul_acc    <= '0;
              mul_mcand  <= bus.a;
              mul_mplier <= bus.b;
              mul_cnt    <= SW'(XLEN - 1);
              state      <= MUL;
            end else if (dec_shift) begin
              if (dec_shamt == '0) begin
                c_q       <= bus.a;
                illegal_q <= 1'b0;
                state     <= DONE;
              end else begin
                sh_val   <= bus.a;
                sh_rem   <= dec_shamt;
                sh_left  <= (bus.funct3_ == 3'b001);
                sh_arith <= dec_alt;
                state    <= SHIFT;
              end
            end else begin
              c_q       <= alu_res;
              illegal_q <= 1'b0;
              state     <= DONE;
            end
          end
        end

        SHIFT: begin
          sh_val <= sh_next;
          sh_rem <= sh_rem_next;
          if (sh_rem_next == '0) begin
            c_q       <= sh_next;
            illegal_q <= 1'b0;
            state     <= DONE;
          end
        end

        MUL: begin
          mul_acc    <= mul_sum;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_cnt    <= mul_cnt - 1'b1;
          if (mul_cnt == '0) begin
            c_q       <= mul_sum;
            illegal_q <= 1'b0;
            state     <= DONE;
          end
        end

        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.c         = c_q;
  assign bus.illegal   = illegal_q;
  assign busy          = (state != IDLE);

endmodule
